traffic_sink: RTL
=================

// Module: traffic_sink
// PURPOSE
//  Ejection-side endpoint, the receiving counterpart of the traffic injector.
//  Attaches to router ejection port 0 and consumes every arriving flit.
//  Returns one credit per consumed flit, rebuilds packet boundaries per VC,
//  counts flits and packets, and flags protocol and destination errors.
//  The main bench polls done_o to end simulation after all expected packets arrive.
// PARAMETERS
//  NUM_VC    4   virtual channels tracked (power of 2)
//  VC_BITS   2   log2(NUM_VC)
//  DST_BITS  4   width of flit destination field
//  MY_ID     0   router id of this sink; flits for any other dst are errors
//  CNT_BITS  16  width of flit/packet counters
//  ERR_BITS  8   width of error counters
// PORTS
//  clk           in   1         system clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  init_i        in   1         1-cycle pulse: clear stats, latch exp_pkts_i
//  exp_pkts_i    in   CNT_BITS  packets expected before done_o asserts
//  flit_full_i   in   1         flit valid (BufferFull)
//  flit_vc_i     in   VC_BITS   flit VC (BufferVc)
//  flit_head_i   in   1         head flag (FlitHead)
//  flit_tail_i   in   1         tail flag (FlitTail)
//  flit_dst_i    in   DST_BITS  destination id (FlitDst)
//  cr_full_o     out  1         credit valid, returned to the upstream router
//  cr_vc_o       out  VC_BITS   VC the credit is for
//  flit_cnt_o    out  CNT_BITS  flits consumed since init
//  pkt_cnt_o     out  CNT_BITS  complete packets since init
//  err_seq_o     out  ERR_BITS  head/tail sequencing errors
//  err_dst_o     out  ERR_BITS  misrouted flits (dst != MY_ID)
//  done_o        out  1         pkt_cnt_o >= expected and every VC IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, expected=0, every VC state IDLE.
//  Always ready: no backpressure; every flit with flit_full_i=1 is consumed.
//  Credit: registered, 1-cycle latency. A flit on VC v at edge N gives
//    cr_full_o=1 and cr_vc_o=v for the cycle after N. Otherwise cr_full_o=0.
//    A credit is returned for every flit, including errored ones and flits
//    that arrive with init_i. Credits are never lost.
//  Per-VC FSM {IDLE, BODY}, updated only by flits on that VC:
//    IDLE  head&tail  -> IDLE, pkt+1
//    IDLE  head&!tail -> BODY
//    IDLE  !head      -> IDLE, err_seq+1 (orphan body/tail, not counted as pkt)
//    BODY  head       -> err_seq+1, treat as new head (tail? IDLE,pkt+1 : BODY)
//    BODY  !head&tail -> IDLE, pkt+1
//    BODY  !head&!tail-> BODY
//  Every valid flit: flit_cnt+1; err_dst+1 if flit_dst_i != MY_ID.
//    A misrouted flit still advances the VC FSM.
//  Counters saturate at all-ones and never wrap.
//  init_i (synchronous): counters and VC FSMs cleared, expected<=exp_pkts_i.
//    A flit in the same cycle is ignored for stats; its credit is still sent.
//  done_o is registered, computed from post-update state:
//    (pkt_cnt >= expected) && all VCs IDLE.
//    expected=0 gives done_o=1 on the cycle after init.
//    Once set, done_o stays high until init or reset. A later orphan flit
//    only bumps err_seq.
//  Reset mid-packet: all VCs return to IDLE at once. Pending credit dropped;
//    the upstream router is reset together with the sink.
// TESTING
//  1 reset, idle 10 cycles -> all outputs 0, cr_full_o never 1
//  2 init exp=1; VC2 flits H,B,B,T on consecutive cycles, dst=MY_ID ->
//    4 credits vc=2 each 1 cycle late; flit_cnt=4, pkt_cnt=1; done_o high
//    the cycle after the T flit
//  3 interleave VC0 H(t0), VC1 H&T(t1), VC0 T(t2) -> pkt_cnt=2, err_seq=0
//  4 VC3 body without head, then H,H,T -> err_seq=2, pkt_cnt=1, credits=4
//  5 flit dst=MY_ID+1 single-flit pkt -> err_dst=1, pkt_cnt=1, credit returned
//  6 VC0 H, then rst_n low 1 cycle mid-packet, then VC0 T ->
//    outputs 0 after reset; err_seq=1 after T; init with flit -> flit uncounted, credit sent

Source files
------------

// File: rtl/traffic_sink.sv
// Ejection-side endpoint: consumes every flit, returns credits, rebuilds packet
// boundaries per VC, and keeps flit/packet/error statistics plus a done flag.
module traffic_sink #(
  parameter int unsigned NUM_VC   = 4,
  parameter int unsigned VC_BITS  = 2,
  parameter int unsigned DST_BITS = 4,
  parameter int unsigned MY_ID    = 0,
  parameter int unsigned CNT_BITS = 16,
  parameter int unsigned ERR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_i,
  input  logic [CNT_BITS-1:0] exp_pkts_i,
  input  logic                flit_full_i,
  input  logic [VC_BITS-1:0]  flit_vc_i,
  input  logic                flit_head_i,
  input  logic                flit_tail_i,
  input  logic [DST_BITS-1:0] flit_dst_i,
  output logic                cr_full_o,
  output logic [VC_BITS-1:0]  cr_vc_o,
  output logic [CNT_BITS-1:0] flit_cnt_o,
  output logic [CNT_BITS-1:0] pkt_cnt_o,
  output logic [ERR_BITS-1:0] err_seq_o,
  output logic [ERR_BITS-1:0] err_dst_o,
  output logic                done_o
);

  typedef enum logic {VC_IDLE = 1'b0, VC_BODY = 1'b1} vc_state_e;

  vc_state_e           vc_state_q   [NUM_VC];
  vc_state_e           vc_state_nxt [NUM_VC];
  logic                armed_q, armed_nxt;
  logic [CNT_BITS-1:0] expected_q, expected_nxt;

  logic                count_c, pkt_done_c, seq_err_c, dst_err_c, all_idle_c;
  logic                cur_body_c;
  logic [CNT_BITS-1:0] flit_cnt_nxt, pkt_cnt_nxt;
  logic [ERR_BITS-1:0] err_seq_nxt, err_dst_nxt;
  logic                done_nxt;

  // State register: per-VC packet FSMs, expected-packet target, init seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) vc_state_q[v] <= VC_IDLE;
      armed_q    <= 1'b0;
      expected_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) vc_state_q[v] <= vc_state_nxt[v];
      armed_q    <= armed_nxt;
      expected_q <= expected_nxt;
    end
  end

  // Next state: only the VC carrying the flit moves; init clears everything
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) vc_state_nxt[v] = vc_state_q[v];
    armed_nxt    = armed_q;
    expected_nxt = expected_q;
    count_c      = 1'b0;
    pkt_done_c   = 1'b0;
    seq_err_c    = 1'b0;
    dst_err_c    = 1'b0;
    cur_body_c   = (vc_state_q[flit_vc_i] == VC_BODY);
    if (init_i) begin
      for (int v = 0; v < NUM_VC; v++) vc_state_nxt[v] = VC_IDLE;
      armed_nxt    = 1'b1;
      expected_nxt = exp_pkts_i;
    end else if (flit_full_i) begin
      count_c   = 1'b1;
      dst_err_c = (flit_dst_i != DST_BITS'(MY_ID));
      // A head inside a packet and a non-head outside one are both sequencing errors
      seq_err_c = (cur_body_c == flit_head_i);
      if (flit_head_i) begin
        pkt_done_c              = flit_tail_i;
        vc_state_nxt[flit_vc_i] = flit_tail_i ? VC_IDLE : VC_BODY;
      end else if (cur_body_c && flit_tail_i) begin
        pkt_done_c              = 1'b1;
        vc_state_nxt[flit_vc_i] = VC_IDLE;
      end
    end
  end

  // Outputs: saturating counters and sticky done from post-update state
  always_comb begin
    flit_cnt_nxt = flit_cnt_o;
    pkt_cnt_nxt  = pkt_cnt_o;
    err_seq_nxt  = err_seq_o;
    err_dst_nxt  = err_dst_o;
    all_idle_c   = 1'b1;
    for (int v = 0; v < NUM_VC; v++)
      if (vc_state_nxt[v] != VC_IDLE) all_idle_c = 1'b0;
    if (init_i) begin
      flit_cnt_nxt = '0;
      pkt_cnt_nxt  = '0;
      err_seq_nxt  = '0;
      err_dst_nxt  = '0;
    end else begin
      if (count_c && (flit_cnt_o != '1))   flit_cnt_nxt = flit_cnt_o + CNT_BITS'(1);
      if (pkt_done_c && (pkt_cnt_o != '1)) pkt_cnt_nxt  = pkt_cnt_o + CNT_BITS'(1);
      if (seq_err_c && (err_seq_o != '1))  err_seq_nxt  = err_seq_o + ERR_BITS'(1);
      if (dst_err_c && (err_dst_o != '1))  err_dst_nxt  = err_dst_o + ERR_BITS'(1);
    end
    done_nxt = (done_o && !init_i) ||
               (armed_nxt && (pkt_cnt_nxt >= expected_nxt) && all_idle_c);
  end

  // Output registers; the credit mirrors the previous cycle's flit regardless of init
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_full_o  <= 1'b0;
      cr_vc_o    <= '0;
      flit_cnt_o <= '0;
      pkt_cnt_o  <= '0;
      err_seq_o  <= '0;
      err_dst_o  <= '0;
      done_o     <= 1'b0;
    end else begin
      cr_full_o  <= flit_full_i;
      cr_vc_o    <= flit_full_i ? flit_vc_i : '0;
      flit_cnt_o <= flit_cnt_nxt;
      pkt_cnt_o  <= pkt_cnt_nxt;
      err_seq_o  <= err_seq_nxt;
      err_dst_o  <= err_dst_nxt;
      done_o     <= done_nxt;
    end
  end

endmodule
